// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and defaults for the PWM compare block.
// Holds the FSM state enum, default WIDTH/DEADTIME and the duty saturate helper.
package pwm_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_DEADTIME = 4;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DRAIN
    } pwm_state_e;

    // Clamp a requested duty to the full period 2^w.
    function automatic logic [31:0] sat_duty(input logic [31:0] d, input int w);
        logic [31:0] full;
        full = 32'd1 << w;
        return (d > full) ? full : d;
    endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// pwm_compare_if: valid/ready channel carrying new duty values.
// Ports: duty_data (WIDTH+1), duty_valid, duty_ready; master drives data/valid.
interface pwm_compare_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH:0] duty_data;
    logic           duty_valid;
    logic           duty_ready;

    modport master (
        output duty_data,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_data,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: inserts a dead band on every edge of the registered raw PWM.
// Ports: clk, rst, raw, active in; pwm, pwm_n out (both low while counting).
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = PWM_DEADTIME
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic active,
    output logic pwm,
    output logic pwm_n
);

    localparam int CW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

    logic          raw_d;
    logic [CW-1:0] dt_cnt;
    logic [CW-1:0] dt_nx;
    logic          quiet;

    // Every raw transition restarts the dead band, so short pulses vanish.
    always_comb begin
        dt_nx = '0;
        if (raw != raw_d) begin
            dt_nx = CW'(DEADTIME);
        end else if (dt_cnt != '0) begin
            dt_nx = dt_cnt - 1'b1;
        end
    end

    assign quiet = (dt_nx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_d  <= 1'b0;
            dt_cnt <= '0;
            pwm    <= 1'b0;
            pwm_n  <= 1'b0;
        end else begin
            raw_d  <= raw;
            dt_cnt <= dt_nx;
            pwm    <= active && quiet && raw;
            pwm_n  <= active && quiet && !raw;
        end
    end

endmodule

// File: rtl/pwm_compare.sv
// pwm_compare: period-aligned PWM from a live count and double-buffered duty.
// Ports: clk, rst, count, enable, duty (slave channel), pwm, pwm_n
// (only with PWM_DEADTIME_EN), period_done, running.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DEADTIME = PWM_DEADTIME
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    pwm_compare_if.slave     duty,
    output logic             pwm,
`ifdef PWM_DEADTIME_EN
    output logic             pwm_n,
`endif
    output logic             period_done,
    output logic             running
);

    localparam int DW = WIDTH + 1;

    pwm_state_e     state;
    pwm_state_e     state_nx;
    logic [WIDTH:0] active_duty;
    logic [WIDTH:0] shadow_duty;
    logic [WIDTH:0] duty_eff;
    logic           pending;
    logic           boundary;
    logic           accept;
    logic           raw;
    logic           out_nx;

    assign boundary        = (count == '0);
    assign duty.duty_ready = !pending;
    assign accept          = duty.duty_valid && !pending;

    // A duty swapped in at the boundary already governs count 0.
    assign duty_eff = (boundary && pending) ? shadow_duty : active_duty;
    assign raw      = ({1'b0, count} < duty_eff);
    assign running  = (state != IDLE);

    // accept needs !pending, so it can never collide with the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_duty <= '0;
            shadow_duty <= '0;
            pending     <= 1'b0;
        end else if (boundary && pending) begin
            active_duty <= shadow_duty;
            pending     <= 1'b0;
        end else if (accept) begin
            shadow_duty <= DW'(sat_duty(32'(duty.duty_data), WIDTH));
            pending     <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        out_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nx = SYNC;
            end
            SYNC: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (boundary) begin
                    state_nx = RUN;
                    out_nx   = raw;
                end
            end
            RUN: begin
                out_nx = raw;
                if (!enable) state_nx = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_nx = RUN;
                    out_nx   = raw;
                end else if (boundary) begin
                    state_nx = IDLE;
                end else begin
                    out_nx = raw;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            period_done <= 1'b0;
        end else begin
            state       <= state_nx;
            period_done <= (state == RUN) && boundary;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic pwm_q;
    logic act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
            act_q <= 1'b0;
        end else begin
            pwm_q <= out_nx;
            act_q <= (state_nx == RUN) || (state_nx == DRAIN);
        end
    end

    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk    (clk),
        .rst    (rst),
        .raw    (pwm_q),
        .active (act_q),
        .pwm    (pwm),
        .pwm_n  (pwm_n)
    );
`else
    always_ff @(posedge clk) begin
        if (rst) pwm <= 1'b0;
        else     pwm <= out_nx;
    end
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: directed bench for pwm_compare (default build).
// Drives count/enable/duty per cycle and checks per-period statistics.
module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] count;
    logic       pwm;
    logic       period_done;
    logic       running;
`ifdef PWM_DEADTIME_EN
    logic       pwm_n;
`endif

    pwm_compare_if #(.WIDTH(8)) duty_bus ();

    always #5 clk = ~clk;

    pwm_compare #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .enable      (enable),
        .duty        (duty_bus),
        .pwm         (pwm),
`ifdef PWM_DEADTIME_EN
        .pwm_n       (pwm_n),
`endif
        .period_done (period_done),
        .running     (running)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int highs, pd_mid, ready_low, run_low, pd0, acc_cnt;
    logic [7:0] prev;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        highs     = 0;
        pd_mid    = 0;
        ready_low = 0;
        run_low   = 0;
        pd0       = 0;
        acc_cnt   = -1;
    endtask

    // One clock: outputs seen afterwards belong to the count just sampled.
    task automatic cyc();
        logic acc;
        acc = duty_bus.duty_valid && duty_bus.duty_ready;
        @(posedge clk);
        #1;
        prev  = count;
        count = count + 8'd1;
        if (acc) begin
            duty_bus.duty_valid = 1'b0;
            acc_cnt = int'(prev);
        end
        if (pwm) highs++;
        if (prev == 8'd0) pd0 = int'(period_done);
        else if (period_done) pd_mid++;
        if (!duty_bus.duty_ready) ready_low++;
        if (!running) run_low++;
    endtask

    task automatic run_to(input logic [7:0] tgt);
        do cyc(); while (count != tgt);
    endtask

    task automatic offer(input int v);
        duty_bus.duty_data  = 9'(v);
        duty_bus.duty_valid = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        count  = 8'd0;
        duty_bus.duty_data  = '0;
        duty_bus.duty_valid = 1'b0;
        clr();
        cyc();
        cyc();
        check("rst_pwm", int'(pwm), 0);
        check("rst_pd", int'(period_done), 0);
        check("rst_run", int'(running), 0);
        check("rst_rdy", int'(duty_bus.duty_ready), 1);

        rst   = 1'b0;
        count = 8'd37;
        offer(64);
        cyc();
        check("idle_acc_rdy", int'(duty_bus.duty_ready), 0);
        check("idle_run", int'(running), 0);

        enable = 1'b1;
        clr();
        run_to(8'd0);
        check("sync_hi", highs, 0);
        check("sync_runlow", run_low, 0);

        clr();
        run_to(8'd0);
        check("w1_hi", highs, 64);
        check("w1_pdmid", pd_mid, 0);

        clr();
        run_to(8'd100);
        offer(200);
        run_to(8'd150);
        offer(10);
        run_to(8'd0);
        check("w2_pd0", pd0, 1);
        check("w2_hi", highs, 64);
        check("w2_rdylow", ready_low, 156);
        check("w2_pdmid", pd_mid, 0);

        clr();
        run_to(8'd0);
        check("w3_pd0", pd0, 1);
        check("w3_hi", highs, 200);
        check("w3_rdylow", ready_low, 255);
        check("w3_acc", acc_cnt, 1);

        clr();
        run_to(8'd5);
        offer(0);
        run_to(8'd0);
        check("w4_hi", highs, 10);

        clr();
        run_to(8'd5);
        offer(300);
        run_to(8'd0);
        check("w5_hi", highs, 0);

        clr();
        run_to(8'd5);
        offer(128);
        run_to(8'd0);
        check("w6_hi", highs, 256);

        clr();
        run_to(8'd10);
        enable = 1'b0;
        run_to(8'd0);
        check("w7_hi", highs, 128);
        check("w7_runlow", run_low, 0);

        cyc();
        check("drain_pwm", int'(pwm), 0);
        check("drain_run", int'(running), 0);
        run_to(8'd20);
        check("idle2_run", int'(running), 0);

        enable = 1'b1;
        cyc();
        check("en_run", int'(running), 1);
        clr();
        run_to(8'd0);
        check("sync2_hi", highs, 0);

        clr();
        run_to(8'd10);
        enable = 1'b0;
        run_to(8'd50);
        enable = 1'b1;
        run_to(8'd0);
        check("w9_hi", highs, 128);
        check("w9_runlow", run_low, 0);

        clr();
        run_to(8'd20);
        offer(30);
        run_to(8'd50);
        check("w10_pd0", pd0, 1);
        check("w10_rdy", int'(duty_bus.duty_ready), 0);
        rst = 1'b1;
        cyc();
        check("rst2_pwm", int'(pwm), 0);
        check("rst2_pd", int'(period_done), 0);
        check("rst2_run", int'(running), 0);
        check("rst2_rdy", int'(duty_bus.duty_ready), 1);
        rst = 1'b0;

        clr();
        run_to(8'd0);
        check("sync3_hi", highs, 0);

        clr();
        run_to(8'd0);
        check("w11_hi", highs, 0);
        check("w11_rdylow", ready_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
